// File: rtl/pixel_shift_pkg.sv
// Shared constants and FSM state type for the pixel shift-out block.
package pixel_shift_pkg;
  localparam int LANES          = 8;
  localparam int LEDS_PER_LANE  = 16;
  localparam int BITS_PER_LANE  = 384;
  localparam int LATCH_CYCLES   = 2;
  localparam int BYTES_PER_LANE = BITS_PER_LANE / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    SHIFT    = 2'd2,
    LATCH    = 2'd3
  } state_e;
endpackage

// File: rtl/pixel_bank_ram.sv
// Two 512x8 banks: bank_sel picks the write bank, the other bank feeds the registered read port.
module pixel_bank_ram (
  input  logic       clk,
  input  logic       bank_sel,
  input  logic       we,
  input  logic [8:0] waddr,
  input  logic [7:0] wdata,
  input  logic [8:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [0:1023];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[{bank_sel, waddr}] <= wdata;
    rdata_q <= mem[{~bank_sel, raddr}];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/pixel_shift_out.sv
// Double-buffered 8-lane serializer for a 128-LED RGB column (16 LEDs per lane, MSB first).
// Define PIXEL_SHIFT_OVERRUN_CNT_EN to build the saturating rejected-start counter.
module pixel_shift_out
  import pixel_shift_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] pixel_addr,
  input  logic [7:0] pixel_data,
  input  logic       store_pixel,
  input  logic       pixel_shift_start,
  output logic       sclk_o,
  output logic [7:0] sdo_o,
  output logic       latch_o,
  output logic       busy_o,
  output logic       overrun_o,
  output logic [7:0] overrun_cnt_o
);
  localparam logic [1:0] PH_HIGH = 2'(SCLK_HALF);
  localparam logic [1:0] PH_LAST = 2'(2 * SCLK_HALF - 1);
  localparam logic [5:0] BYTE_LAST = 6'(BYTES_PER_LANE - 1);

  state_e                       state_q, state_d;
  logic                         bank_sel_q, bank_sel_d;
  logic [1:0]                   ph_q, ph_d;
  logic [2:0]                   bit_q, bit_d;
  logic [5:0]                   byte_q, byte_d;
  logic [1:0]                   latch_cnt_q, latch_cnt_d;
  logic [LANES-1:0][7:0]        shreg_q, shreg_d;
  logic [LANES-1:0][7:0]        hold_q, hold_d;
  logic                         fetch_act_q, fetch_act_d;
  logic [2:0]                   fetch_lane_q, fetch_lane_d;
  logic [3:0]                   fetch_led_q, fetch_led_d;
  logic [1:0]                   fetch_comp_q, fetch_comp_d;
  logic                         rd_vld_q, rd_vld_d;
  logic [2:0]                   rd_lane_q, rd_lane_d;
  logic                         sclk_q, sclk_d;
  logic                         overrun_q, overrun_d;
  logic                         wr_en;
  logic [8:0]                   rd_addr;
  logic [7:0]                   rd_data;

  assign wr_en   = store_pixel && (pixel_addr[1:0] != 2'd3);
  assign rd_addr = {fetch_lane_q, fetch_led_q, fetch_comp_q};

  pixel_bank_ram u_ram (
    .clk      (clk),
    .bank_sel (bank_sel_q),
    .we       (wr_en),
    .waddr    (pixel_addr),
    .wdata    (pixel_data),
    .raddr    (rd_addr),
    .rdata    (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    bank_sel_d   = bank_sel_q;
    ph_d         = ph_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    latch_cnt_d  = latch_cnt_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    fetch_act_d  = fetch_act_q;
    fetch_lane_d = fetch_lane_q;
    fetch_led_d  = fetch_led_q;
    fetch_comp_d = fetch_comp_q;
    rd_vld_d     = fetch_act_q;
    rd_lane_d    = fetch_lane_q;
    overrun_d    = pixel_shift_start && (state_q != IDLE);

    if (rd_vld_q) hold_d[rd_lane_q] = rd_data;

    // One read per lane per byte period; the byte pointer advances after lane 7.
    if (fetch_act_q) begin
      fetch_lane_d = fetch_lane_q + 3'd1;
      if (fetch_lane_q == 3'(LANES - 1)) begin
        fetch_act_d = 1'b0;
        if (fetch_comp_q == 2'd2) begin
          fetch_comp_d = 2'd0;
          fetch_led_d  = fetch_led_q + 4'd1;
        end else begin
          fetch_comp_d = fetch_comp_q + 2'd1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (pixel_shift_start) begin
          state_d      = PREFETCH;
          bank_sel_d   = ~bank_sel_q;
          fetch_act_d  = 1'b1;
          fetch_lane_d = 3'd0;
          fetch_led_d  = 4'd0;
          fetch_comp_d = 2'd0;
        end
      end
      PREFETCH: begin
        if (!fetch_act_q && !rd_vld_q) begin
          state_d = SHIFT;
          shreg_d = hold_q;
          ph_d    = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 6'd0;
        end
      end
      SHIFT: begin
        // Fetch for the next byte runs in the background well inside one byte period.
        if (ph_q == 2'd0 && bit_q == 3'd0 && byte_q != BYTE_LAST) begin
          fetch_act_d  = 1'b1;
          fetch_lane_d = 3'd0;
        end
        if (ph_q == PH_LAST) begin
          ph_d = 2'd0;
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (byte_q == BYTE_LAST) begin
              state_d     = LATCH;
              latch_cnt_d = 2'd0;
              shreg_d     = '0;
            end else begin
              byte_d  = byte_q + 6'd1;
              shreg_d = hold_q;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            for (int l = 0; l < LANES; l++) shreg_d[l] = {shreg_q[l][6:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      LATCH: begin
        if (latch_cnt_q == 2'(LATCH_CYCLES - 1)) state_d = IDLE;
        else latch_cnt_d = latch_cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase

    sclk_d = (state_d == SHIFT) && (ph_d >= PH_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bank_sel_q   <= 1'b0;
      ph_q         <= 2'd0;
      bit_q        <= 3'd0;
      byte_q       <= 6'd0;
      latch_cnt_q  <= 2'd0;
      shreg_q      <= '0;
      hold_q       <= '0;
      fetch_act_q  <= 1'b0;
      fetch_lane_q <= 3'd0;
      fetch_led_q  <= 4'd0;
      fetch_comp_q <= 2'd0;
      rd_vld_q     <= 1'b0;
      rd_lane_q    <= 3'd0;
      sclk_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_sel_q   <= bank_sel_d;
      ph_q         <= ph_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      latch_cnt_q  <= latch_cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      fetch_act_q  <= fetch_act_d;
      fetch_lane_q <= fetch_lane_d;
      fetch_led_q  <= fetch_led_d;
      fetch_comp_q <= fetch_comp_d;
      rd_vld_q     <= rd_vld_d;
      rd_lane_q    <= rd_lane_d;
      sclk_q       <= sclk_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    sdo_o = '0;
    for (int l = 0; l < LANES; l++) sdo_o[l] = (state_q == SHIFT) && shreg_q[l][7];
  end

  assign sclk_o    = sclk_q;
  assign latch_o   = (state_q == LATCH);
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

`ifdef PIXEL_SHIFT_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_q && ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_cnt_q <= 8'd0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt_o = ovr_cnt_q;
`else
  assign overrun_cnt_o = 8'd0;
`endif
endmodule

// File: doc/pixel_shift_out.md
PIXEL_SHIFT_OUT -- requirements
Module: pixel_shift_out

Interface
REQ-001 Parameter SCLK_HALF, default 1, sets clk cycles per sclk_o half-period; legal values are 1 and 2.
REQ-002 clk  in  1  system clock, 30 MHz.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pixel_addr  in  9  byte address {led[6:0], comp[1:0]}, where comp 0=R, 1=G, 2=B.
REQ-005 pixel_data  in  8  component byte to store.
REQ-006 store_pixel  in  1  single-cycle write strobe for pixel_data at pixel_addr.
REQ-007 pixel_shift_start  in  1  single-cycle pulse marking that the LED column is complete.
REQ-008 sclk_o  out  1  serial clock shared by all lanes.
REQ-009 sdo_o  out  8  serial data, one bit per lane.
REQ-010 latch_o  out  1  driver latch pulse.
REQ-011 busy_o  out  1  high while a frame is being shifted.
REQ-012 overrun_o  out  1  single-cycle pulse when a start is rejected.
REQ-013 overrun_cnt_o  out  8  count of rejected starts.
REQ-014 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-015 Storage SHALL be two banks of 512x8, one write bank and one read bank, swapped only on an accepted start.
REQ-016 store_pixel SHALL write the write bank at pixel_addr; writes with comp=3 SHALL be ignored.
REQ-017 When store_pixel and an accepted start occur in the same cycle, the write SHALL land in the bank being handed to the shifter.
REQ-018 The FSM SHALL have the states IDLE, PREFETCH, SHIFT and LATCH.
REQ-019 A start in IDLE SHALL be accepted: the banks swap on the next edge and the FSM goes to PREFETCH.
REQ-020 A start in any other state SHALL be ignored, SHALL pulse overrun_o for one cycle, and SHALL leave the banks unchanged.
REQ-021 Lane L (0..7) SHALL carry LEDs 16L..16L+15, in ascending LED order, as R, G, B bytes, MSB first.
REQ-022 Each lane SHALL therefore carry 384 bits per frame.
REQ-023 PREFETCH SHALL read 8 bytes, one per lane, through the 1-cycle-latency RAM, then load the lane shift registers and enter SHIFT.
REQ-024 During SHIFT, the 8 holding bytes for the next byte period SHALL be fetched in the background.
REQ-025 RAM reads SHALL never stall the shift.
REQ-026 sdo_o SHALL change only while sclk_o is low.
REQ-027 Each bit SHALL be held SCLK_HALF cycles with sclk_o low, then SCLK_HALF cycles with sclk_o high.
REQ-028 After the 384th bit's high phase, sclk_o SHALL return low and the FSM SHALL enter LATCH.
REQ-029 latch_o SHALL be high for exactly 2 cycles, after which the FSM returns to IDLE.
REQ-030 busy_o SHALL be high in PREFETCH, SHIFT and LATCH.
REQ-031 With SCLK_HALF=1, start-to-latch-fall SHALL be at most 790 cycles, which is below the 1536-cycle column period.

Reset
REQ-032 rst SHALL force IDLE and set every output to 0.
REQ-033 rst SHALL reset the bank-select and counters; RAM contents are not cleared.
REQ-034 rst asserted mid-frame SHALL abort immediately, with no latch pulse and sdo_o/sclk_o low on the next cycle.

Configuration
REQ-035 With PIXEL_SHIFT_OVERRUN_CNT_EN defined, overrun_cnt_o SHALL increment on each overrun_o pulse, saturate at 255, and clear only on rst.
REQ-036 Without PIXEL_SHIFT_OVERRUN_CNT_EN, overrun_cnt_o SHALL be tied to 0 and no counter logic SHALL be built; overrun_o is present in both builds.

Structure
REQ-037 Package pixel_shift_pkg SHALL hold LANES=8, LEDS_PER_LANE=16, BITS_PER_LANE=384, LATCH_CYCLES=2 and the state enum.
REQ-038 Sub-module pixel_bank_ram SHALL hold the two 512x8 banks: one write port, one registered read port and a bank-select input.

Verification
REQ-039 Store led k bytes R=k, G=0x80|k, B=~k, then start -> lane 0 shows 0x00,0x80,0xFF... MSB first; lane 7 begins 0x70,0xF0,0x8F; then exactly 2 latch cycles.
REQ-040 Second start at 100 cycles after the first -> overrun_o pulses once, overrun_cnt_o=1 (macro on), and the frame output is unchanged.
REQ-041 Store led 5 R=0xAA in the same cycle as start -> lane 0 LED 5 R byte shifts as 0xAA.
REQ-042 Write during SHIFT to led 5 R=0x55 -> the current frame is unaffected; the next frame shows 0x55.
REQ-043 rst at bit 200 -> next cycle all outputs 0, no latch, busy_o=0; a following start runs a full frame correctly.
REQ-044 Write with comp=3 -> no bank change; SCLK_HALF=2 -> 768 sclk_o-high cycles per frame.
